// File: rtl/fifo_reader.sv
// fifo_reader: drains a programmed number of words from a synchronous FIFO
// read port, hides the FIFO's 1-cycle read latency, and presents the words on
// a valid/ready stream through a 2-entry skid buffer.
// Optional build macro: FIFO_READER_STALL_CNT_EN adds a saturating stall_cnt
// output counting cycles with m_valid && !m_ready.
module fifo_reader #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    input  logic                  abort,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      rd_count,
`ifdef FIFO_READER_STALL_CNT_EN
    output logic [CNT_W-1:0]      stall_cnt,
`endif
    output logic                  underflow_err
);

    localparam int unsigned OCC_W = 2;
    localparam int unsigned LVL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic [FIFO_WIDTH-1:0] buf0_q, buf0_d;
    logic [FIFO_WIDTH-1:0] buf1_q, buf1_d;
    logic [CNT_W-1:0]      rd_count_q, rd_count_d;
    logic                  underflow_err_q, underflow_err_d;

    logic                  pop;
    logic                  capture;
    logic [LVL_W-1:0]      level;

    // Stream side is a direct view of the buffer head and occupancy.
    assign m_valid       = (occ_q != OCC_W'(0));
    assign m_data        = buf0_q;
    assign rd_count      = rd_count_q;
    assign underflow_err = underflow_err_q;

    // Handshake and projected buffer fill (held words plus the word in flight).
    always_comb begin
        pop     = m_valid && m_ready;
        capture = inflight_q && !fifo_underflow;
        level   = LVL_W'(occ_q) - LVL_W'(pop) + LVL_W'(inflight_q);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (burst_len != LEN_W'(0)) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                if (abort || (fifo_rd_en && (remaining_q == LEN_W'(1)))) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!inflight_q && (occ_q == OCC_W'(0))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs; a read is issued only when the buffer can still absorb it.
    always_comb begin
        fifo_rd_en = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_READ: begin
                fifo_rd_en = !fifo_empty && (remaining_q != LEN_W'(0))
                             && (level < LVL_W'(2));
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Datapath next state: issue counter, in-flight tracking, skid buffer, counters.
    always_comb begin
        remaining_d     = remaining_q;
        inflight_d      = fifo_rd_en;
        occ_d           = occ_q;
        buf0_d          = buf0_q;
        buf1_d          = buf1_q;
        rd_count_d      = rd_count_q;
        underflow_err_d = underflow_err_q;

        if ((state_q == ST_IDLE) && start) begin
            remaining_d = burst_len;
        end else if (fifo_rd_en) begin
            remaining_d = remaining_q - LEN_W'(1);
        end

        if (inflight_q && fifo_underflow) begin
            underflow_err_d = 1'b1;
        end

        case ({capture, pop})
            2'b10: begin
                if (occ_q == OCC_W'(0)) begin
                    buf0_d = fifo_data_out;
                end else begin
                    buf1_d = fifo_data_out;
                end
                occ_d = occ_q + OCC_W'(1);
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - OCC_W'(1);
            end
            2'b11: begin
                if (occ_q == OCC_W'(2)) begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_data_out;
                end else begin
                    buf0_d = fifo_data_out;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase

        if (pop) begin
            rd_count_d = rd_count_q + CNT_W'(1);
        end
    end

    // Datapath registers; reset discards the in-flight word and buffered data.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            occ_q           <= '0;
            buf0_q          <= '0;
            buf1_q          <= '0;
            rd_count_q      <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            occ_q           <= occ_d;
            buf0_q          <= buf0_d;
            buf1_q          <= buf1_d;
            rd_count_q      <= rd_count_d;
            underflow_err_q <= underflow_err_d;
        end
    end

`ifdef FIFO_READER_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    assign stall_cnt = stall_cnt_q;

    // Saturating count of cycles where the stream is held off by the sink.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (m_valid && !m_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural 1-cycle-latency FIFO.
module tb_fifo_reader;

    localparam int unsigned FW = 16;
    localparam int unsigned LW = 8;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          abort = 1'b0;
    logic          fifo_rd_en;
    logic [FW-1:0] fifo_data_out = '0;
    logic          fifo_empty;
    logic          fifo_underflow = 1'b0;
    logic [FW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] rd_count;
    logic          underflow_err;
`ifdef FIFO_READER_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    // FIFO model storage: written only by the stimulus, read pointer owned by the model.
    logic [FW-1:0] mem [0:63];
    int wp = 0;
    int rp = 0;

    // Stream / read-port monitor.
    logic [FW-1:0] got [0:63];
    int ngot = 0;
    int nrd = 0;
    int ndone = 0;

    fifo_reader #(.FIFO_WIDTH(FW), .LEN_W(LW), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .burst_len(burst_len),
        .abort(abort),
        .fifo_rd_en(fifo_rd_en),
        .fifo_data_out(fifo_data_out),
        .fifo_empty(fifo_empty),
        .fifo_underflow(fifo_underflow),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .busy(busy),
        .done(done),
        .rd_count(rd_count),
`ifdef FIFO_READER_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rp == wp);

    // FIFO read port: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (fifo_rd_en && (rp != wp)) begin
            fifo_data_out <= mem[rp];
            rp <= rp + 1;
        end
    end

    // Record delivered words, issued reads and done pulses.
    always @(posedge clk) begin
        if (rst === 1'b0) begin
            if (m_valid && m_ready) begin
                got[ngot] <= m_data;
                ngot <= ngot + 1;
            end
            if (fifo_rd_en) nrd <= nrd + 1;
            if (done) ndone <= ndone + 1;
        end
    end

    task automatic push(input logic [FW-1:0] w);
        mem[wp] = w;
        wp = wp + 1;
    endtask

    task automatic wait_done(input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if ({fifo_rd_en, m_valid, busy, done} !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_ctrl cyc%0d: got rd_en/valid/busy/done=%b expected 0000", i,
                         {fifo_rd_en, m_valid, busy, done});
            end
            vectors++;
            if (rd_count !== CW'(0) || underflow_err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_cnt cyc%0d: got rd_count=%0d err=%b expected 0/0", i,
                         rd_count, underflow_err);
            end
        end
    endtask

    task automatic test_basic();
        logic [8:0] e_rd, e_v, e_done, e_busy;
        int d0;
        e_rd   = 9'b000001111;
        e_v    = 9'b000111100;
        e_done = 9'b010000000;
        e_busy = 9'b011111111;
        for (int k = 1; k <= 4; k++) push(FW'(k));
        m_ready = 1'b1;
        d0 = ndone;
        @(negedge clk);
        start = 1'b1;
        burst_len = LW'(4);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            vectors++;
            if ({fifo_rd_en, m_valid, done, busy} !== {e_rd[i], e_v[i], e_done[i], e_busy[i]}) begin
                miscompares++;
                $display("FAIL basic_ctrl cyc%0d: got rd_en/valid/done/busy=%b expected %b", i,
                         {fifo_rd_en, m_valid, done, busy}, {e_rd[i], e_v[i], e_done[i], e_busy[i]});
            end
            if (e_v[i]) begin
                vectors++;
                if (m_data !== FW'(i - 1)) begin
                    miscompares++;
                    $display("FAIL basic_data cyc%0d: got %h expected %h", i, m_data, FW'(i - 1));
                end
            end
        end
        vectors++;
        if (rd_count !== CW'(4) || ndone - d0 !== 1) begin
            miscompares++;
            $display("FAIL basic_end: got rd_count=%0d dones=%0d expected 4/1", rd_count, ndone - d0);
        end
    endtask

    task automatic test_backpressure();
        int n0, r0;
        bit seen;
        for (int k = 0; k < 6; k++) push(16'hA000 + FW'(k));
        m_ready = 1'b0;
        n0 = ngot;
        r0 = nrd;
        @(negedge clk);
        start = 1'b1;
        burst_len = LW'(6);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            vectors++;
            if (fifo_rd_en !== (i < 2)) begin
                miscompares++;
                $display("FAIL bp_rd_en cyc%0d: got %b expected %b", i, fifo_rd_en, (i < 2));
            end
        end
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 16'hA000 || nrd - r0 !== 2) begin
            miscompares++;
            $display("FAIL bp_hold: got valid=%b data=%h reads=%0d expected 1/a000/2",
                     m_valid, m_data, nrd - r0);
        end
        m_ready = 1'b1;
        wait_done(40, seen);
        vectors++;
        if (seen !== 1'b1 || ngot - n0 !== 6 || nrd - r0 !== 6) begin
            miscompares++;
            $display("FAIL bp_drain: got done=%b words=%0d reads=%0d expected 1/6/6",
                     seen, ngot - n0, nrd - r0);
        end
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (got[n0 + k] !== 16'hA000 + FW'(k)) begin
                miscompares++;
                $display("FAIL bp_word%0d: got %h expected %h", k, got[n0 + k], 16'hA000 + FW'(k));
            end
        end
        vectors++;
        if (rd_count !== CW'(10)) begin
            miscompares++;
            $display("FAIL bp_count: got %0d expected 10", rd_count);
        end
        @(negedge clk);
    endtask

    task automatic test_empty_stall();
        int n0, d0;
        bit seen;
        push(16'hB000);
        push(16'hB001);
        m_ready = 1'b1;
        n0 = ngot;
        d0 = ndone;
        @(negedge clk);
        start = 1'b1;
        burst_len = LW'(5);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if (ngot - n0 !== 2 || fifo_rd_en !== 1'b0 || busy !== 1'b1 || ndone !== d0) begin
            miscompares++;
            $display("FAIL stall_wait: got words=%0d rd_en=%b busy=%b dones=%0d expected 2/0/1/0",
                     ngot - n0, fifo_rd_en, busy, ndone - d0);
        end
        for (int k = 2; k < 5; k++) push(16'hB000 + FW'(k));
        wait_done(30, seen);
        vectors++;
        if (seen !== 1'b1 || ngot - n0 !== 5 || rd_count !== CW'(15)) begin
            miscompares++;
            $display("FAIL stall_resume: got done=%b words=%0d rd_count=%0d expected 1/5/15",
                     seen, ngot - n0, rd_count);
        end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (got[n0 + k] !== 16'hB000 + FW'(k)) begin
                miscompares++;
                $display("FAIL stall_word%0d: got %h expected %h", k, got[n0 + k], 16'hB000 + FW'(k));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int n0, r0, obs;
        bit seen;
        for (int k = 0; k < 10; k++) push(16'hC000 + FW'(k));
        m_ready = 1'b1;
        n0 = ngot;
        r0 = nrd;
        obs = 0;
        @(negedge clk);
        start = 1'b1;
        burst_len = LW'(10);
        // abort coincides with the cycle carrying the 3rd read
        for (int i = 0; i < 10 && obs < 3; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (fifo_rd_en) obs++;
            if (obs == 3) abort = 1'b1;
        end
        vectors++;
        if (obs !== 3) begin
            miscompares++;
            $display("FAIL abort_third_read: got %0d reads observed expected 3", obs);
        end
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (fifo_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_rd_en: got %b expected 0", fifo_rd_en);
        end
        wait_done(20, seen);
        vectors++;
        if (seen !== 1'b1 || nrd - r0 !== 3 || ngot - n0 !== 3 || wp - rp !== 7) begin
            miscompares++;
            $display("FAIL abort_end: got done=%b reads=%0d words=%0d left=%0d expected 1/3/3/7",
                     seen, nrd - r0, ngot - n0, wp - rp);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got[n0 + k] !== 16'hC000 + FW'(k)) begin
                miscompares++;
                $display("FAIL abort_word%0d: got %h expected %h", k, got[n0 + k], 16'hC000 + FW'(k));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        int n0;
        m_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        burst_len = LW'(2);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 16'hC003) begin
            miscompares++;
            $display("FAIL rstmid_pre: got valid=%b data=%h expected 1/c003", m_valid, m_data);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || rd_count !== CW'(0) || fifo_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_post: got valid=%b busy=%b rd_count=%0d rd_en=%b expected 0/0/0/0",
                     m_valid, busy, rd_count, fifo_rd_en);
        end
        rst = 1'b0;
        m_ready = 1'b1;
        n0 = ngot;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (m_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_ghost cyc%0d: got valid=%b data=%h expected 0", i, m_valid, m_data);
            end
        end
        vectors++;
        if (ngot - n0 !== 0) begin
            miscompares++;
            $display("FAIL rstmid_words: got %0d expected 0", ngot - n0);
        end
    endtask

    task automatic test_underflow();
        int n0;
        bit seen;
        m_ready = 1'b1;
        n0 = ngot;
        @(negedge clk);
        start = 1'b1;
        burst_len = LW'(2);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        fifo_underflow = 1'b1;
        @(negedge clk);
        fifo_underflow = 1'b0;
        vectors++;
        if (underflow_err !== 1'b1 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL uf_flag: got err=%b valid=%b expected 1/0", underflow_err, m_valid);
        end
        wait_done(20, seen);
        vectors++;
        if (seen !== 1'b1 || ngot - n0 !== 1 || got[n0] !== 16'hC006 || rd_count !== CW'(1)) begin
            miscompares++;
            $display("FAIL uf_end: got done=%b words=%0d first=%h rd_count=%0d expected 1/1/c006/1",
                     seen, ngot - n0, got[n0], rd_count);
        end
        @(negedge clk);
        vectors++;
        if (underflow_err !== 1'b1) begin
            miscompares++;
            $display("FAIL uf_sticky: got %b expected 1", underflow_err);
        end
    endtask

    task automatic test_zero_len();
        int r0, d0;
        r0 = nrd;
        d0 = ndone;
        @(negedge clk);
        start = 1'b1;
        burst_len = LW'(0);
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if ({done, busy, fifo_rd_en} !== 3'b110) begin
            miscompares++;
            $display("FAIL zero_done: got done/busy/rd_en=%b expected 110", {done, busy, fifo_rd_en});
        end
        @(negedge clk);
        vectors++;
        if ({done, busy} !== 2'b00 || nrd - r0 !== 0 || ndone - d0 !== 1) begin
            miscompares++;
            $display("FAIL zero_idle: got done/busy=%b reads=%0d dones=%0d expected 00/0/1",
                     {done, busy}, nrd - r0, ndone - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_stall();
        test_abort();
        test_reset_midflight();
        test_underflow();
        test_zero_len();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Read-side consumer for the team's synchronous FIFO; the reader counterpart to the FIFO writer path.
- On a start request it drains a programmed number of words through the FIFO read port (rd_en / data_out / empty / underflow).
- It absorbs the FIFO's 1-cycle read latency and delivers words on a valid/ready stream.
- A 2-entry skid buffer ensures downstream backpressure never loses or duplicates data.

Parameters:
FIFO_WIDTH, 16, width of FIFO data words
LEN_W, 8, width of burst_len and internal remaining-issue counter
CNT_W, 16, width of rd_count

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
start  input  1  1-cycle request to begin a burst; sampled only in IDLE
burst_len  input  LEN_W  words to read; sampled with start
abort  input  1  stop issuing new reads (READ state only)
fifo_rd_en  output  1  FIFO read enable
fifo_data_out  input  FIFO_WIDTH  FIFO read data
fifo_empty  input  1  FIFO empty flag
fifo_underflow  input  1  FIFO underflow flag
m_data  output  FIFO_WIDTH  stream data (buffer head)
m_valid  output  1  stream valid
m_ready  input  1  stream ready
busy  output  1  high in any state except IDLE
done  output  1  1-cycle pulse at burst completion
rd_count  output  CNT_W  total words delivered on the stream; wraps modulo 2^CNT_W
underflow_err  output  1  sticky; cleared only by rst

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; fifo_rd_en=0, m_valid=0, m_data=0, busy=0, done=0, rd_count=0, underflow_err=0; buffer occupancy=0; in-flight flag=0.
- Read latency: a word read with fifo_rd_en=1 in cycle N is on fifo_data_out in cycle N+1. It is captured into the buffer at the posedge ending cycle N+1 and is presented with m_valid=1 from cycle N+2.
- Buffer:
  - 2 entries, FIFO order; m_valid = (occ!=0); m_data = head entry.
  - pop = m_valid && m_ready.
  - Simultaneous capture and pop in the same cycle is legal; occ stays unchanged.
- Issue rule:
  - fifo_rd_en = (state==READ) && !fifo_empty && remaining!=0 && (occ - pop + inflight) < 2.
  - Combinational from registered state and inputs; guarantees no overflow of the 2-entry buffer.
  - Sustains 1 word/cycle when m_ready=1.
- FSM:
  - IDLE: start && burst_len!=0 → READ, remaining=burst_len. start && burst_len==0 → DONE. Otherwise stay in IDLE.
  - READ: each issued read decrements remaining. When remaining reaches 0 (after the last issue), or abort=1 → FLUSH. fifo_empty=1 stalls issue; the block stays in READ indefinitely.
  - FLUSH: no new reads; waits for inflight==0 && occ==0 → DONE.
  - DONE: done=1 for exactly this cycle → IDLE.
  - start in any non-IDLE state is ignored; abort outside READ is ignored.
- Underflow: if fifo_underflow=1 in the cycle a word is in flight, the word is discarded (not captured, not counted), underflow_err sets, and the FSM continues.
- rd_count: increments on each pop.
- rst mid-operation: next cycle all state returns to reset values; the in-flight word and buffered words are discarded.

Optional Feature:
- Macro FIFO_READER_STALL_CNT_EN.
- Defined: adds output stall_cnt, width CNT_W, reset 0. It increments every cycle with m_valid && !m_ready, saturates at all-ones, and clears on rst.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- rst held 3 cycles, then released with start=0 → fifo_rd_en=0, m_valid=0, busy=0, rd_count=0 throughout.
- FIFO preloaded 0x0001..0x0004, start with burst_len=4, m_ready=1 → fifo_rd_en high 4 consecutive cycles; m_data 0x0001..0x0004 on 4 consecutive cycles, first 2 cycles after first rd_en; done pulses once; rd_count=4.
- FIFO holds 6 words, burst_len=6, m_ready=0 → exactly 2 reads issued, then fifo_rd_en=0, m_valid=1 with m_data=first word. Raise m_ready → all 6 delivered in order, no duplicates.
- FIFO holds 2 words, burst_len=5 → 2 words delivered, then stays READ with fifo_rd_en=0 and busy=1. Write 3 more words → remaining 3 delivered; done; rd_count=5.
- burst_len=10, abort pulsed after 3rd rd_en → no further reads; 3 words delivered; done; FIFO retains its other words.
- rst pulsed while a word is in flight and occ=1 → next cycle m_valid=0, busy=0, rd_count=0; the word is never presented.
